// File: rtl/wrapper_ram.sv
// Read-only lookup memory: 32 words of 36 lanes, lane k of word a holds (a << 16) | k.
// Contents are generated at elaboration; the registered output is the only state.
module wrapper_ram #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int LANE_W = 32,
  parameter int LANES  = 36
) (
  input  logic                      clka,
  input  logic                      rsta,
  input  logic [ADDR_W-1:0]         addra,
  output logic [LANES*LANE_W-1:0]   douta
);

  localparam int WORD_W = LANES * LANE_W;

  function automatic logic [WORD_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [WORD_W-1:0] w;
    logic [31:0]       lane;
    w = '0;
    for (int k = 0; k < LANES; k++) begin
      lane = (32'(a) << 16) | 32'(k);
      w[k*LANE_W +: LANE_W] = LANE_W'(lane);
    end
    return w;
  endfunction

  logic [WORD_W-1:0] rom_s [DEPTH];
  logic [WORD_W-1:0] douta_d;
  logic [WORD_W-1:0] douta_q;

  // Constant table: one fixed word per address, no storage behind it.
  for (genvar a = 0; a < DEPTH; a++) begin : g_rom
    assign rom_s[a] = rom_word(ADDR_W'(a));
  end

  // Next output word selected by the sampled address.
  always_comb begin
    douta_d = rom_s[addra];
  end

  // Output register; reset clears it immediately.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      douta_q <= '0;
    end else begin
      douta_q <= douta_d;
    end
  end

  assign douta = douta_q;

endmodule

// File: tb/tb_wrapper_ram.sv
// Directed bench for wrapper_ram: reset behaviour, one-cycle latency, wrap,
// mid-cycle address changes, asynchronous mid-run reset and a full address sweep.
module tb_wrapper_ram;

  localparam int ADDR_W = 5;
  localparam int LANE_W = 32;
  localparam int LANES  = 36;
  localparam int WORD_W = LANES * LANE_W;

  logic              clka;
  logic              rsta;
  logic [ADDR_W-1:0] addra;
  logic [WORD_W-1:0] douta;

  int vectors;
  int miscompares;

  wrapper_ram #(
    .ADDR_W(ADDR_W),
    .DEPTH (32),
    .LANE_W(LANE_W),
    .LANES (LANES)
  ) dut (
    .clka (clka),
    .rsta (rsta),
    .addra(addra),
    .douta(douta)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Reference word built as a*65536 + k per lane.
  function automatic logic [WORD_W-1:0] model_word(input int a);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int k = 0; k < LANES; k++) begin
      w[k*LANE_W +: LANE_W] = 32'(a) * 32'h0001_0000 + 32'(k);
    end
    return w;
  endfunction

  function automatic logic [31:0] lane_of(input logic [WORD_W-1:0] w, input int k);
    return w[k*LANE_W +: LANE_W];
  endfunction

  task automatic check_lane(input string tag, input int k, input logic [31:0] exp);
    logic [31:0] obs;
    obs = lane_of(douta, k);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s lane %0d: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [WORD_W-1:0] exp);
    vectors++;
    assert (douta === exp) else begin
      miscompares++;
      $error("FAIL %s: observed lane0 %h lane35 %h expected lane0 %h lane35 %h",
             tag, lane_of(douta, 0), lane_of(douta, 35), lane_of(exp, 0), lane_of(exp, 35));
    end
  endtask

  task automatic edge_sample();
    @(posedge clka);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WORD_W-1:0] zero_w;
    zero_w      = '0;
    vectors     = 0;
    miscompares = 0;

    // Reset held with clock running and addra = 7.
    rsta  = 1'b1;
    addra = 5'd7;
    #1;
    check_word("reset_t0", zero_w);
    edge_sample();
    check_word("reset_edge1", zero_w);
    edge_sample();
    check_word("reset_edge2", zero_w);

    // First read after release.
    @(negedge clka);
    rsta  = 1'b0;
    addra = 5'd0;
    edge_sample();
    check_lane("first_read", 0, 32'h0000_0000);
    check_lane("first_read", 1, 32'h0000_0001);
    check_lane("first_read", 35, 32'h0000_0023);
    check_word("first_read_word", model_word(0));

    // One-cycle latency, address 3 then 4.
    @(negedge clka);
    addra = 5'd3;
    edge_sample();
    check_lane("latency_n", 0, 32'h0003_0000);
    check_lane("latency_n", 35, 32'h0003_0023);
    @(negedge clka);
    addra = 5'd4;
    edge_sample();
    check_lane("latency_n1", 0, 32'h0004_0000);

    // Top address then wrap to 0.
    @(negedge clka);
    addra = 5'd31;
    edge_sample();
    check_lane("top_addr", 10, 32'h001F_000A);
    check_lane("top_addr", 35, 32'h001F_0023);
    @(negedge clka);
    addra = 5'd0;
    edge_sample();
    check_lane("wrap_addr", 10, 32'h0000_000A);

    // Repeated address returns identical data.
    edge_sample();
    check_word("repeat_addr", model_word(0));

    // Mid-cycle address change has no effect until the next edge.
    @(negedge clka);
    addra = 5'd5;
    edge_sample();
    check_lane("midcycle_before", 1, 32'h0005_0001);
    #2;
    addra = 5'd9;
    #1;
    check_lane("midcycle_hold", 1, 32'h0005_0001);
    edge_sample();
    check_lane("midcycle_after", 1, 32'h0009_0001);

    // Asynchronous reset pulse between edges while reading address 12.
    @(negedge clka);
    addra = 5'd12;
    edge_sample();
    check_lane("pre_reset", 2, 32'h000C_0002);
    #2;
    rsta = 1'b1;
    #1;
    check_word("async_reset", zero_w);
    edge_sample();
    check_word("reset_held_edge", zero_w);
    @(negedge clka);
    rsta = 1'b0;
    #1;
    check_word("post_release_no_edge", zero_w);
    edge_sample();
    check_lane("post_reset_read", 2, 32'h000C_0002);

    // Back-to-back sweep over every address.
    for (int a = 0; a < 32; a++) begin
      @(negedge clka);
      addra = 5'(a);
      edge_sample();
      check_word($sformatf("sweep_%0d", a), model_word(a));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
